// File: rtl/mips_pkg.sv
// Shared types and constants for the data-memory responder.
// The error-cause encoding is reserved for a future detailed error report.
package mips_pkg;

    localparam int WORD_BYTES = 4;
    localparam int LAT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmr_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2
    } dmr_err_cause_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );

endinterface

// File: rtl/dmr_word_array.sv
// DEPTH x 32 word storage with synchronous write and a registered read port.
// The read register holds data only in the cycle after a read strobe and is zero otherwise.
module dmr_word_array #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[idx_i] <= wdata_i;
            end
            rdata_q <= re_i ? mem_q[idx_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time and answers
// after LATENCY wait states with a one-cycle response strobe.
module data_mem_responder
    import mips_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  mem_if
);

    localparam int ADDR_W   = $clog2(DEPTH);
    localparam bit ZERO_LAT = (LATENCY == 0);

    if (LATENCY < 0 || LATENCY > (2 ** LAT_W) - 1) begin : g_bad_latency
        $error("data_mem_responder: LATENCY %0d outside 0..15", LATENCY);
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("data_mem_responder: DEPTH %0d is not a power of two >= 4", DEPTH);
    end

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * WORD_BYTES));
    endfunction

    dmr_state_e        state_q;
    logic [LAT_W-1:0]  cnt_q;
    logic              write_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic              ready_q;
    logic              resp_valid_q;
    logic              resp_err_q;

    logic              req_err;
    logic [ADDR_W-1:0] req_idx;
    logic              op_write;
    logic [ADDR_W-1:0] op_idx;
    logic [31:0]       op_wdata;
    logic              op_err;
    logic              enter_resp;
    logic              mem_we;
    logic              mem_re;
    logic [31:0]       mem_rdata;

    assign req_err = addr_err(mem_if.req_addr);
    assign req_idx = mem_if.req_addr[ADDR_W+1:2];

    // With zero latency the RESP entry coincides with acceptance, so the live request is used.
    assign op_write = ZERO_LAT ? mem_if.req_write : write_q;
    assign op_idx   = ZERO_LAT ? req_idx          : idx_q;
    assign op_wdata = ZERO_LAT ? mem_if.req_wdata : wdata_q;
    assign op_err   = ZERO_LAT ? req_err          : err_q;

    assign enter_resp = ZERO_LAT ? (state_q == IDLE && mem_if.req_valid)
                                 : (state_q == WAIT && cnt_q == LAT_W'(1));
    assign mem_we = enter_resp && op_write && !op_err;
    assign mem_re = enter_resp && !op_write && !op_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= enter_resp;
            resp_err_q   <= enter_resp && op_err;
            case (state_q)
                IDLE: begin
                    if (mem_if.req_valid) begin
                        write_q <= mem_if.req_write;
                        idx_q   <= req_idx;
                        wdata_q <= mem_if.req_wdata;
                        err_q   <= req_err;
                        ready_q <= 1'b0;
                        if (ZERO_LAT) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= LAT_W'(LATENCY);
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - LAT_W'(1);
                    if (cnt_q == LAT_W'(1)) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    dmr_word_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_word_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .idx_i   (op_idx),
        .wdata_i (op_wdata),
        .rdata_o (mem_rdata)
    );

    assign mem_if.req_ready  = ready_q;
    assign mem_if.busy       = ~ready_q;
    assign mem_if.resp_valid = resp_valid_q;
    assign mem_if.resp_err   = resp_err_q;
    assign mem_if.resp_rdata = mem_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance at LATENCY=2 and one at LATENCY=0,
// driven one at a time and compared against a word-array model of the memory.
module tb_data_mem_responder;

    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // sel=1 drives the LATENCY=2 instance, sel=0 the LATENCY=0 instance
    bit          sel = 1'b1;
    logic        valid = 1'b0;
    logic        write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder_if if2 ();
    data_mem_responder_if if0 ();

    assign if2.req_valid = valid & sel;
    assign if2.req_write = write;
    assign if2.req_addr  = addr;
    assign if2.req_wdata = wdata;
    assign if0.req_valid = valid & ~sel;
    assign if0.req_write = write;
    assign if0.req_addr  = addr;
    assign if0.req_wdata = wdata;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .mem_if (if2.slave)
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .mem_if (if0.slave)
    );

    logic        rdy, bsy, rv, re;
    logic [31:0] rd;
    assign rdy = sel ? if2.req_ready  : if0.req_ready;
    assign bsy = sel ? if2.busy       : if0.busy;
    assign rv  = sel ? if2.resp_valid : if0.resp_valid;
    assign re  = sel ? if2.resp_err   : if0.resp_err;
    assign rd  = sel ? if2.resp_rdata : if0.resp_rdata;

    logic [31:0] model [2][DEPTH];
    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic        eErr;
        logic [31:0] eData;
    } vec_t;

    vec_t vecs [9];

    function automatic bit isErr(input logic [31:0] a);
        return (a % 4 != 0) || (a >= DEPTH * 4);
    endfunction

    function automatic int expLatency();
        return sel ? 2 : 0;
    endfunction

    task automatic clearModel();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++)
                model[s][i] = '0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the first cycle ready is back.
    task automatic applyStimulus(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                 input bit keepValid, output logic gotErr,
                                 output logic [31:0] gotData, output int acceptEdge);
        int  lat;
        int  waitCnt;
        lat     = expLatency();
        gotErr  = 1'b0;
        gotData = '0;
        valid   = 1'b1;
        write   = wr;
        addr    = a;
        wdata   = d;
        waitCnt = 0;
        while (!rdy && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept timeout got ready=0 expected ready=1");
            valid      = 1'b0;
            acceptEdge = cyc;
            return;
        end
        @(posedge clk);
        #1;
        acceptEdge = cyc;
        @(negedge clk);
        valid = keepValid;
        write = ~wr;
        addr  = $urandom;
        wdata = $urandom;
        for (int k = 1; k <= lat + 2; k++) begin
            if (k > 1) @(negedge clk);
            checkOutput($sformatf("ready k=%0d", k), 32'(rdy), 32'(k == lat + 2));
            checkOutput($sformatf("busy k=%0d", k), 32'(bsy), 32'(k != lat + 2));
            checkOutput($sformatf("resp_valid k=%0d", k), 32'(rv), 32'(k == lat + 1));
            if (k == lat + 1) begin
                gotErr  = re;
                gotData = rd;
            end
            if (k == lat + 2) begin
                checkOutput("rdata idle", rd, 32'h0);
                checkOutput("err idle", 32'(re), 32'h0);
            end
        end
    endtask

    task automatic runTxn(input string name, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input bit keepValid, input logic eErr,
                          input logic [31:0] eData, output int acc);
        logic        gErr;
        logic [31:0] gData;
        applyStimulus(wr, a, d, keepValid, gErr, gData, acc);
        checkOutput({name, " err"}, 32'(gErr), 32'(eErr));
        checkOutput({name, " rdata"}, gData, eData);
        if (wr && !isErr(a)) model[sel][a / 4] = d;
    endtask

    task automatic randomTxns(input int n);
        int          acc;
        bit          wr;
        bit          keep;
        int          r;
        logic [31:0] a, d, eData;
        for (int i = 0; i < n; i++) begin
            r  = $urandom_range(0, 9);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = $urandom_range(0, 63);
            else             a = $urandom_range(0, 15) * 4;
            wr   = $urandom_range(0, 1);
            keep = $urandom_range(0, 1);
            d    = $urandom;
            eData = '0;
            if (!wr && !isErr(a)) eData = model[sel][a / 4];
            runTxn($sformatf("rnd%0d sel%0d", i, sel), wr, a, d, keep, isErr(a), eData, acc);
        end
        valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc, prevAcc;

        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h0000_0013, 32'h1234_5678, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0};
        vecs[5] = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hCAFE_F00D};
        vecs[7] = '{1'b0, 32'h0000_03FE, 32'h0,         1'b1, 32'h0};
        vecs[8] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0};
        clearModel();

        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checkOutput($sformatf("reset ready sel%0d", s), 32'(rdy), 32'h1);
            checkOutput($sformatf("reset busy sel%0d", s), 32'(bsy), 32'h0);
            checkOutput($sformatf("reset resp_valid sel%0d", s), 32'(rv), 32'h0);
            checkOutput($sformatf("reset rdata sel%0d", s), rd, 32'h0);
            checkOutput($sformatf("reset err sel%0d", s), 32'(re), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b1;

        $display("[TB] table vectors, LATENCY=2");
        for (int i = 0; i < 9; i++) begin
            runTxn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].a, vecs[i].d, 1'b0,
                   vecs[i].eErr, vecs[i].eData, acc);
        end

        $display("[TB] back-to-back with req_valid held, LATENCY=2");
        runTxn("bb0", 1'b1, 32'h0, 32'h1111_1111, 1'b1, 1'b0, 32'h0, acc);
        prevAcc = acc;
        runTxn("bb1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1111_1111, acc);
        checkOutput("bb1 period", 32'(acc - prevAcc), 32'd4);
        prevAcc = acc;
        runTxn("bb2", 1'b1, 32'h4, 32'h2222_2222, 1'b1, 1'b0, 32'h0, acc);
        checkOutput("bb2 period", 32'(acc - prevAcc), 32'd4);
        prevAcc = acc;
        runTxn("bb3", 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h2222_2222, acc);
        checkOutput("bb3 period", 32'(acc - prevAcc), 32'd4);
        valid = 1'b0;

        randomTxns(30);

        $display("[TB] zero latency instance");
        sel = 1'b0;
        runTxn("z0 store", 1'b1, 32'h20, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0, acc);
        prevAcc = acc;
        runTxn("z0 load", 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0BAD_F00D, acc);
        checkOutput("z0 period", 32'(acc - prevAcc), 32'd2);
        valid = 1'b0;
        randomTxns(30);

        $display("[TB] reset during WAIT");
        sel   = 1'b1;
        checkOutput("rst-mid ready before", 32'(rdy), 32'h1);
        valid = 1'b1;
        write = 1'b1;
        addr  = 32'h8;
        wdata = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        @(negedge clk);
        valid = 1'b0;
        checkOutput("rst-mid in wait", 32'(rdy), 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("rst-mid ready", 32'(rdy), 32'h1);
        checkOutput("rst-mid resp_valid", 32'(rv), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rst-mid hold rv%0d", i), 32'(rv), 32'h0);
        end
        rst = 1'b0;
        clearModel();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rst-mid after rv%0d", i), 32'(rv), 32'h0);
            checkOutput($sformatf("rst-mid after ready%0d", i), 32'(rdy), 32'h1);
        end
        runTxn("rst-mid load", 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
